// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: owns the fetch PC, issues sequential requests and
// redirects fetch after the branch delay slot or on exception/ERET.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fs_allowin,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        br_valid,
  input  logic [31:0] br_pc,
  input  logic        br_taken,
  input  logic        j_taken,
  input  logic        jr_taken,
  input  logic [31:0] br_target,
  input  logic [31:0] j_target,
  input  logic [31:0] jr_target,
  input  logic        exc_valid,
  input  logic [31:0] exc_pc,
  output logic        wrong_path,
  output logic        redirect_pend
);

  typedef enum logic [1:0] {SEQ, DS, TGT} state_t;

  state_t      state, state_n;
  logic [31:0] req_pc, req_pc_n;
  logic [31:0] last_pc;
  logic [31:0] tgt, tgt_n;
  logic        accept;
  logic        taken;
  logic [31:0] target;

  assign inst_req      = ~reset & fs_allowin;
  assign inst_addr     = req_pc;
  assign redirect_pend = (state != SEQ);
  assign accept        = inst_req & inst_addr_ok;
  assign taken         = br_valid & (br_taken | j_taken | jr_taken);
  assign target        = jr_taken ? jr_target : (j_taken ? j_target : br_target);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SEQ;
      req_pc  <= RESET_PC;
      last_pc <= RESET_PC - 32'd4;
      tgt     <= 32'd0;
    end else begin
      state  <= state_n;
      req_pc <= req_pc_n;
      tgt    <= tgt_n;
      if (accept) last_pc <= req_pc;
    end
  end

  always_comb begin
    state_n    = state;
    req_pc_n   = req_pc;
    tgt_n      = tgt;
    wrong_path = 1'b0;
    if (exc_valid) begin
      state_n  = SEQ;
      req_pc_n = exc_pc;
    end else begin
      unique case (state)
        SEQ: begin
          if (taken) begin
            // last_pc == br_pc means the delay slot has not been accepted yet
            if (last_pc == br_pc && !accept) begin
              state_n = DS;
              tgt_n   = target;
            end else begin
              state_n    = TGT;
              req_pc_n   = target;
              wrong_path = accept && (last_pc != br_pc);
            end
          end else if (accept) begin
            req_pc_n = req_pc + 32'd4;
          end
        end
        DS: if (accept) begin
          state_n  = TGT;
          req_pc_n = tgt;
        end
        TGT: if (accept) begin
          state_n  = SEQ;
          req_pc_n = req_pc + 32'd4;
        end
        default: state_n = SEQ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized
// run against a reference model of the fetch address stream.
module tb_pc_sequencer;
  localparam logic [31:0] RST = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset, fs_allowin, inst_addr_ok;
  logic        inst_req, wrong_path, redirect_pend;
  logic [31:0] inst_addr;
  logic        br_valid, br_taken, j_taken, jr_taken, exc_valid;
  logic [31:0] br_pc, br_target, j_target, jr_target, exc_pc;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: next fetch address, last accepted address, and the
  // pending-redirect bookkeeping (slot still owed / next fetch is the target)
  logic [31:0] m_pc, m_last, m_tgt;
  logic        m_owed, m_at_tgt;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .fs_allowin(fs_allowin),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .br_valid(br_valid), .br_pc(br_pc),
    .br_taken(br_taken), .j_taken(j_taken), .jr_taken(jr_taken),
    .br_target(br_target), .j_target(j_target), .jr_target(jr_target),
    .exc_valid(exc_valid), .exc_pc(exc_pc),
    .wrong_path(wrong_path), .redirect_pend(redirect_pend)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clr_br();
    br_valid = 0; br_taken = 0; j_taken = 0; jr_taken = 0; exc_valid = 0;
  endtask

  // one clock: check outputs against the model mid-cycle, advance model at the edge
  task automatic cyc();
    logic        acc, tk, e_wp;
    logic [31:0] t, n_pc, n_last, n_tgt;
    logic        n_owed, n_at;
    @(negedge clk);
    acc  = !reset && fs_allowin && inst_addr_ok;
    tk   = br_valid && (br_taken || j_taken || jr_taken);
    t    = br_target;
    if (j_taken)  t = j_target;
    if (jr_taken) t = jr_target;
    e_wp = !reset && !exc_valid && !m_owed && !m_at_tgt && tk && acc && (m_last != br_pc);
    chk("inst_req", inst_req, !reset && fs_allowin);
    chk("inst_addr", inst_addr, m_pc);
    chk("wrong_path", wrong_path, e_wp);
    chk("redirect_pend", redirect_pend, m_owed || m_at_tgt);
    n_pc = m_pc; n_last = m_last; n_tgt = m_tgt; n_owed = m_owed; n_at = m_at_tgt;
    if (reset) begin
      n_pc = RST; n_last = RST - 32'd4; n_tgt = 0; n_owed = 0; n_at = 0;
    end else begin
      if (acc) n_last = m_pc;
      if (exc_valid) begin
        n_pc = exc_pc; n_owed = 0; n_at = 0;
      end else if (m_owed) begin
        if (acc) begin n_pc = m_tgt; n_owed = 0; n_at = 1; end
      end else if (m_at_tgt) begin
        if (acc) begin n_pc = m_pc + 32'd4; n_at = 0; end
      end else if (tk) begin
        if (m_last == br_pc && !acc) begin n_owed = 1; n_tgt = t; end
        else begin n_pc = t; n_at = 1; end
      end else if (acc) begin
        n_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    m_pc = n_pc; m_last = n_last; m_tgt = n_tgt; m_owed = n_owed; m_at_tgt = n_at;
    #1;
  endtask

  initial begin
    reset = 1; fs_allowin = 1; inst_addr_ok = 1;
    br_pc = 0; br_target = 0; j_target = 0; jr_target = 0; exc_pc = 0;
    clr_br();
    m_pc = RST; m_last = RST - 32'd4; m_tgt = 0; m_owed = 0; m_at_tgt = 0;
    @(posedge clk); #1;
    cyc(); cyc();
    chk("reset_req_low", inst_req, 1'b0);
    chk("reset_addr", inst_addr, RST);

    // sequential fetch from reset
    reset = 0;
    #1 chk("seq0", inst_addr, RST);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("seq_addr", inst_addr, RST + 32'(4 * (k + 1)));
    end

    // taken branch resolved while its delay slot is accepted
    br_valid = 1; br_taken = 1; br_pc = 32'hBFC0_0010; br_target = 32'h8000_1000;
    cyc(); clr_br();
    chk("br_tgt", inst_addr, 32'h8000_1000);
    chk("br_pend", redirect_pend, 1'b1);
    cyc();
    chk("br_tgt4", inst_addr, 32'h8000_1004);
    chk("br_pend_clr", redirect_pend, 1'b0);

    // capture before the slot is accepted, then memory stalls
    cyc();
    br_valid = 1; br_taken = 1; br_pc = 32'h8000_1004; br_target = 32'h8000_2000;
    inst_addr_ok = 0;
    cyc(); clr_br(); cyc(); cyc();
    chk("ds_hold", inst_addr, 32'h8000_1008);
    chk("ds_pend", redirect_pend, 1'b1);
    inst_addr_ok = 1;
    cyc();
    chk("ds_tgt", inst_addr, 32'h8000_2000);
    cyc();
    chk("ds_seq", inst_addr, 32'h8000_2004);

    // slot already accepted: same-cycle accept is wrong path
    cyc();
    br_valid = 1; j_taken = 1; br_pc = 32'h8000_2000; j_target = 32'h8000_3000;
    #1 chk("wp_flag", wrong_path, 1'b1);
    cyc(); clr_br();
    chk("wp_tgt", inst_addr, 32'h8000_3000);

    // exception beats a same-cycle jr capture
    br_valid = 1; jr_taken = 1; br_pc = m_last; jr_target = 32'h1234_5678;
    exc_valid = 1; exc_pc = 32'hBFC0_0380;
    cyc(); clr_br();
    chk("exc_addr", inst_addr, 32'hBFC0_0380);
    chk("exc_pend", redirect_pend, 1'b0);

    // address wrap
    exc_valid = 1; exc_pc = 32'hFFFF_FFFC;
    cyc(); clr_br();
    chk("wrap_pre", inst_addr, 32'hFFFF_FFFC);
    cyc();
    chk("wrap", inst_addr, 32'h0000_0000);

    // reset while in the delay-slot wait
    cyc();
    br_valid = 1; br_taken = 1; br_pc = m_last; br_target = 32'h0000_4000;
    inst_addr_ok = 0;
    cyc(); clr_br();
    chk("ds_rst_pend", redirect_pend, 1'b1);
    reset = 1; inst_addr_ok = 1;
    cyc();
    chk("rst_req_low", inst_req, 1'b0);
    reset = 0;
    #1 chk("rst_addr", inst_addr, RST);
    chk("rst_pend", redirect_pend, 1'b0);

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 59) == 0);
      fs_allowin   = ($urandom_range(0, 9) < 8);
      inst_addr_ok = ($urandom_range(0, 9) < 7);
      br_valid     = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 2))
        0: br_pc = m_last;
        1: br_pc = m_last - 32'd4;
        default: br_pc = $urandom;
      endcase
      br_taken  = $urandom_range(0, 1) == 1;
      j_taken   = $urandom_range(0, 3) == 0;
      jr_taken  = $urandom_range(0, 3) == 0;
      br_target = $urandom; j_target = $urandom; jr_target = $urandom;
      exc_valid = ($urandom_range(0, 24) == 0);
      exc_pc    = (i % 7 == 0) ? 32'hFFFF_FFFC : $urandom;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
